// File: rtl/weight_bram_arbiter_pkg.sv
// Shared constants, layer weight map and FSM encoding for the weight BRAM arbiter.
package weight_bram_pkg;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned W          = 8;
  localparam int unsigned ADDR_WIDTH = 18;
  localparam int unsigned LEN_WIDTH  = 19;
  localparam int unsigned RD_LATENCY = 2;

  // Weight BRAM layout: one contiguous region per layer
  localparam int unsigned LAYER1_1_BASE = 0;
  localparam int unsigned LAYER1_1_LEN  = 9216;
  localparam int unsigned LAYER1_2_BASE = 9216;
  localparam int unsigned LAYER1_2_LEN  = 9216;
  localparam int unsigned LAYER1_3_BASE = 18432;
  localparam int unsigned LAYER1_3_LEN  = 9216;
  localparam int unsigned LAYER1_4_BASE = 27648;
  localparam int unsigned LAYER1_4_LEN  = 9216;
  localparam int unsigned LAYER1_5_BASE = 36864;
  localparam int unsigned LAYER1_5_LEN  = 9216;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/weight_bram_arbiter_rr_arbiter.sv
// Round-robin selector: first requester at or after ptr, wrapping mod NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   next_ptr
);

  int unsigned idx;
  logic        found;

  // Scan requesters starting at ptr; the first hit wins and the pointer moves past it
  always_comb begin
    winner   = '0;
    next_ptr = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[PTR_W'(idx)]) begin
        found                 = 1'b1;
        winner[PTR_W'(idx)]   = 1'b1;
        next_ptr              = PTR_W'((idx + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/weight_bram_arbiter.sv
// Shares the read-only weight BRAM between loaders; one burst at a time, round-robin.
module weight_bram_arbiter #(
  parameter int unsigned NUM_REQ    = weight_bram_pkg::NUM_REQ,
  parameter int unsigned W          = weight_bram_pkg::W,
  parameter int unsigned ADDR_WIDTH = weight_bram_pkg::ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = weight_bram_pkg::LEN_WIDTH,
  parameter int unsigned RD_LATENCY = weight_bram_pkg::RD_LATENCY
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_base,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              grant,
  output logic [W-1:0]                    rd_data,
  output logic                            rd_valid,
  output logic                            rd_last,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic                            bram_en,
  output logic                            bram_ren,
  output logic [ADDR_WIDTH-1:0]           bram_addr,
  input  logic [W-1:0]                    bram_dout
);

  import weight_bram_pkg::*;

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW    = LEN_WIDTH + 1;

  state_t                  state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]      winner;
  logic [PTR_W-1:0]        next_ptr;
  logic [ADDR_WIDTH-1:0]   sel_base;
  logic [LEN_WIDTH-1:0]    sel_len;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [CW-1:0]           count;
  logic                    last_issue;
  logic [RD_LATENCY-1:0]   pipe_valid;
  logic [RD_LATENCY-1:0]   pipe_last;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req      (req),
    .ptr      (rr_ptr),
    .winner   (winner),
    .next_ptr (next_ptr)
  );

  // Mux the winning loader's base and length out of the packed request buses
  always_comb begin
    sel_base = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        sel_base = req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign last_issue = (count + CW'(1)) == {1'b0, len_q};

  // Burst FSM: arbitration, address issue and completion with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      base_q    <= '0;
      len_q     <= '0;
      count     <= '0;
      grant     <= '0;
      done      <= '0;
      bram_en   <= 1'b0;
      bram_ren  <= 1'b0;
      bram_addr <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant  <= winner;
            rr_ptr <= next_ptr;
            base_q <= sel_base;
            len_q  <= sel_len;
            count  <= '0;
            if (sel_len == '0) begin
              // Empty burst: nothing to read, so completion is signalled on entry to DRAIN
              done  <= winner;
              state <= ST_DRAIN;
            end else begin
              bram_en   <= 1'b1;
              bram_ren  <= 1'b1;
              bram_addr <= sel_base;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (last_issue) begin
            bram_ren <= 1'b0;
            state    <= ST_DRAIN;
          end else begin
            count     <= count + CW'(1);
            bram_addr <= base_q + ADDR_WIDTH'(count + CW'(1));
          end
        end
        ST_DRAIN: begin
          if (len_q == '0) begin
            grant <= '0;
            state <= ST_IDLE;
          end else if (rd_last) begin
            done      <= grant;
            grant     <= '0;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Valid/last tags travel alongside the BRAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
    end else begin
      for (int unsigned i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
      pipe_valid[0] <= (state == ST_ISSUE);
      pipe_last[0]  <= (state == ST_ISSUE) && last_issue;
    end
  end

  assign rd_valid = pipe_valid[RD_LATENCY-1];
  assign rd_last  = pipe_last[RD_LATENCY-1] & rd_valid;
  assign rd_data  = rd_valid ? bram_dout : '0;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_weight_bram_arbiter.sv
// Directed bench for weight_bram_arbiter with a 2-cycle BRAM model, mem[a] = a[7:0].
module tb_weight_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [71:0] req_base;
  logic [75:0] req_len;
  logic [3:0]  grant;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic [3:0]  done;
  logic        busy;
  logic        bram_en;
  logic        bram_ren;
  logic [17:0] bram_addr;
  logic [7:0]  bram_dout;
  logic [7:0]  bram_s1;

  always #5 clk = ~clk;

  weight_bram_arbiter #(
    .NUM_REQ    (4),
    .W          (8),
    .ADDR_WIDTH (18),
    .LEN_WIDTH  (19),
    .RD_LATENCY (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_base  (req_base),
    .req_len   (req_len),
    .grant     (grant),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .done      (done),
    .busy      (busy),
    .bram_en   (bram_en),
    .bram_ren  (bram_ren),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout)
  );

  // Two-stage read BRAM model
  always @(posedge clk) begin
    if (bram_en && bram_ren) bram_s1 <= bram_addr[7:0];
    bram_dout <= bram_s1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [17:0] b, input logic [18:0] l);
    req_base[i*18 +: 18] = b;
    req_len[i*19 +: 19]  = l;
  endtask

  task automatic set_all(input logic [17:0] b, input logic [18:0] l);
    for (int i = 0; i < 4; i++) set_slot(i, b, l);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    req_base = '0;
    req_len  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [17:0] base;
    logic [18:0] len;
    logic [3:0]  grant;
    logic        valid;
    logic        last;
    logic [7:0]  data;
    logic [3:0]  done;
    logic        busy;
    logic        en;
    logic        ren;
    logic [17:0] addr;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic [3:0] r, logic [17:0] b, logic [18:0] l,
                              logic [3:0] g, logic v, logic la, logic [7:0] d,
                              logic [3:0] dn, logic bs, logic e, logic re, logic [17:0] a);
    vec_t t;
    t.req = r; t.base = b; t.len = l; t.grant = g; t.valid = v; t.last = la;
    t.data = d; t.done = dn; t.busy = bs; t.en = e; t.ren = re; t.addr = a;
    return t;
  endfunction

  // Runs one burst already requested on loader idx; drops req on grant, optionally scrambles inputs
  task automatic run_burst(input int idx, input logic [17:0] b, input int len,
                           input bit mutate, input string tag);
    int beats;
    bit seen_done;
    bit granted;
    beats = 0; seen_done = 0; granted = 0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      @(negedge clk);
      if (rd_valid) begin
        check({tag, "_data"}, rd_data, 64'((b + 18'(beats)) & 18'hff));
        check({tag, "_last"}, rd_last, (beats == len - 1));
        beats++;
      end
      if (!granted && grant[idx]) begin
        granted = 1;
        req[idx] = 1'b0;
        if (mutate) set_slot(idx, b + 18'h19, 19'd7);
      end
      if (done[idx]) seen_done = 1;
    end
    check({tag, "_done_seen"}, seen_done, 1);
    check({tag, "_beats"}, beats, len);
  endtask

  int          order[$];
  int          exp_order[5];
  int          beats2[4];
  int          cur, inburst, d0, dones, nbeats;
  bit          hit;
  logic [3:0]  pg;

  initial begin
    rst = 1'b1;
    req = '0;
    req_base = '0;
    req_len  = '0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_done",  done, 0);
    check("rst_busy",  busy, 0);
    check("rst_en",    bram_en, 0);
    check("rst_ren",   bram_ren, 0);
    check("rst_addr",  bram_addr, 0);
    do_reset();

    // Test 1: loader 0, base 36864, len 4
    vecs[0]  = mk(4'b0001, 18'd36864, 19'd4, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 18'h0);
    vecs[1]  = mk(4'b0000, 18'd36864, 19'd4, 4'b0001, 0, 0, 8'h00, 4'b0000, 1, 1, 1, 18'h09000);
    vecs[2]  = mk(4'b0000, 18'd36864, 19'd4, 4'b0001, 0, 0, 8'h00, 4'b0000, 1, 1, 1, 18'h09001);
    vecs[3]  = mk(4'b0000, 18'd36864, 19'd4, 4'b0001, 1, 0, 8'h00, 4'b0000, 1, 1, 1, 18'h09002);
    vecs[4]  = mk(4'b0000, 18'd36864, 19'd4, 4'b0001, 1, 0, 8'h01, 4'b0000, 1, 1, 1, 18'h09003);
    vecs[5]  = mk(4'b0000, 18'd36864, 19'd4, 4'b0001, 1, 0, 8'h02, 4'b0000, 1, 1, 0, 18'h0);
    vecs[6]  = mk(4'b0000, 18'd36864, 19'd4, 4'b0001, 1, 1, 8'h03, 4'b0000, 1, 1, 0, 18'h0);
    vecs[7]  = mk(4'b0000, 18'd36864, 19'd4, 4'b0000, 0, 0, 8'h00, 4'b0001, 0, 0, 0, 18'h0);
    vecs[8]  = mk(4'b0000, 18'd36864, 19'd4, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 18'h0);
    // Test 3: loader 2, len 0
    vecs[9]  = mk(4'b0100, 18'h0, 19'd0, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 18'h0);
    vecs[10] = mk(4'b0000, 18'h0, 19'd0, 4'b0100, 0, 0, 8'h00, 4'b0100, 1, 0, 0, 18'h0);
    vecs[11] = mk(4'b0000, 18'h0, 19'd0, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 18'h0);
    // Test 4: loader 1, address wrap
    vecs[12] = mk(4'b0010, 18'h3FFFE, 19'd4, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 18'h0);
    vecs[13] = mk(4'b0000, 18'h3FFFE, 19'd4, 4'b0010, 0, 0, 8'h00, 4'b0000, 1, 1, 1, 18'h3FFFE);
    vecs[14] = mk(4'b0000, 18'h3FFFE, 19'd4, 4'b0010, 0, 0, 8'h00, 4'b0000, 1, 1, 1, 18'h3FFFF);
    vecs[15] = mk(4'b0000, 18'h3FFFE, 19'd4, 4'b0010, 1, 0, 8'hFE, 4'b0000, 1, 1, 1, 18'h00000);
    vecs[16] = mk(4'b0000, 18'h3FFFE, 19'd4, 4'b0010, 1, 0, 8'hFF, 4'b0000, 1, 1, 1, 18'h00001);
    vecs[17] = mk(4'b0000, 18'h3FFFE, 19'd4, 4'b0010, 1, 0, 8'h00, 4'b0000, 1, 1, 0, 18'h0);
    vecs[18] = mk(4'b0000, 18'h3FFFE, 19'd4, 4'b0010, 1, 1, 8'h01, 4'b0000, 1, 1, 0, 18'h0);
    vecs[19] = mk(4'b0000, 18'h3FFFE, 19'd4, 4'b0000, 0, 0, 8'h00, 4'b0010, 0, 0, 0, 18'h0);
    vecs[20] = mk(4'b0000, 18'h3FFFE, 19'd4, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 18'h0);

    for (int j = 0; j < 21; j++) begin
      @(negedge clk);
      check($sformatf("v%0d_grant", j), grant,    vecs[j].grant);
      check($sformatf("v%0d_valid", j), rd_valid, vecs[j].valid);
      check($sformatf("v%0d_last", j),  rd_last,  vecs[j].last);
      check($sformatf("v%0d_data", j),  rd_data,  vecs[j].data);
      check($sformatf("v%0d_done", j),  done,     vecs[j].done);
      check($sformatf("v%0d_busy", j),  busy,     vecs[j].busy);
      check($sformatf("v%0d_en", j),    bram_en,  vecs[j].en);
      check($sformatf("v%0d_ren", j),   bram_ren, vecs[j].ren);
      if (vecs[j].ren) check($sformatf("v%0d_addr", j), bram_addr, vecs[j].addr);
      req = vecs[j].req;
      set_all(vecs[j].base, vecs[j].len);
    end

    // Test 2: all four request len 2; loader 0 keeps requesting after its first done
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_slot(i, 18'(16 * i), 19'd2);
      beats2[i] = 0;
    end
    exp_order = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    cur = -1; inburst = 0; d0 = 0; dones = 0; pg = '0;
    for (int c = 0; c < 150 && dones < 5; c++) begin
      @(negedge clk);
      check("t2_onehot", $onehot0(grant), 1);
      if (pg == 4'b0000 && grant != 4'b0000) begin
        for (int i = 0; i < 4; i++) if (grant[i]) cur = i;
        order.push_back(cur);
        inburst = 0;
      end
      pg = grant;
      if (rd_valid) begin
        check("t2_owner", (grant != 4'b0000), 1);
        if (cur >= 0) begin
          check($sformatf("t2_data_l%0d", cur), rd_data, 64'((16 * cur + inburst) & 255));
          beats2[cur]++;
        end
        inburst++;
      end
      if (done != 4'b0000) begin
        dones++;
        for (int i = 0; i < 4; i++) begin
          if (done[i]) begin
            if (i != 0 || d0 == 1) req[i] = 1'b0;
            if (i == 0) d0++;
          end
        end
      end
    end
    check("t2_bursts", dones, 5);
    check("t2_order_len", order.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < order.size()) check($sformatf("t2_order%0d", k), order[k], exp_order[k]);
    check("t2_beats_l0", beats2[0], 4);
    check("t2_beats_l1", beats2[1], 2);
    check("t2_beats_l2", beats2[2], 2);
    check("t2_beats_l3", beats2[3], 2);

    // Test 5: reset on the 3rd beat of a len 8 burst, then a fresh burst
    do_reset();
    set_slot(1, 18'h20, 19'd8);
    req = 4'b0010;
    nbeats = 0; hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (rd_valid) begin
        nbeats++;
        if (nbeats == 3) begin
          hit = 1;
          rst = 1'b1;
          #1;
          check("t5_grant", grant, 0);
          check("t5_valid", rd_valid, 0);
          check("t5_last",  rd_last, 0);
          check("t5_data",  rd_data, 0);
          check("t5_done",  done, 0);
          check("t5_busy",  busy, 0);
          check("t5_en",    bram_en, 0);
          check("t5_ren",   bram_ren, 0);
          check("t5_addr",  bram_addr, 0);
        end
      end
    end
    check("t5_reached_beat3", hit, 1);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5_no_done", done, 0);
      check("t5_idle", busy, 0);
    end
    set_slot(1, 18'h40, 19'd2);
    req = 4'b0010;
    run_burst(1, 18'h40, 2, 1'b0, "t5b");

    // Test 6: inputs scrambled and req dropped mid-burst
    set_slot(3, 18'h80, 19'd3);
    req = 4'b1000;
    run_burst(3, 18'h80, 3, 1'b1, "t6");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_no_regrant", grant, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
